// File: rtl/store_commit_buffer.sv
// Committed-store write buffer: in-order FIFO between the ROB commit port and data memory,
// drained over a req/ack handshake, with a same-word load conflict check.
module store_commit_buffer #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rob_write,
  input  logic [DATA_W/8-1:0]   rob_mask,
  input  logic [ADDR_W-1:0]     rob_addr,
  input  logic [DATA_W-1:0]     rob_data,
  output logic                  rob_write_valid,
  output logic                  mem_req,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [DATA_W/8-1:0]   mem_mask,
  output logic [DATA_W-1:0]     mem_data,
  input  logic                  mem_ack,
  input  logic [ADDR_W-1:0]     ld_check_addr,
  output logic                  ld_conflict,
  output logic                  buf_empty
);

  localparam int unsigned PTR_W   = $clog2(DEPTH);
  localparam int unsigned CNT_W   = PTR_W + 1;
  localparam int unsigned MASK_W  = DATA_W / 8;
  localparam int unsigned WADDR_W = ADDR_W - 2;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_REQ  = 1'b1
  } state_t;

  // Entry storage holds word addresses only; byte offset is never needed.
  logic [WADDR_W-1:0] addr_mem_q [DEPTH];
  logic [MASK_W-1:0]  mask_mem_q [DEPTH];
  logic [DATA_W-1:0]  data_mem_q [DEPTH];

  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  state_t             state_q, state_d;
  logic               mem_req_q, mem_req_d;
  logic [WADDR_W-1:0] mem_waddr_q, mem_waddr_d;
  logic [MASK_W-1:0]  mem_mask_q, mem_mask_d;
  logic [DATA_W-1:0]  mem_data_q, mem_data_d;

  logic               push;
  logic               pop;
  logic [PTR_W-1:0]   offs;
  logic [WADDR_W-1:0] ld_waddr;

  assign rob_write_valid = (count_q < CNT_W'(DEPTH));
  assign push            = rob_write && rob_write_valid;
  assign buf_empty       = (count_q == '0) && !mem_req_q;

  assign mem_req  = mem_req_q;
  assign mem_addr = {mem_waddr_q, 2'b00};
  assign mem_mask = mem_mask_q;
  assign mem_data = mem_data_q;

  // Drain FSM and pointer/count next state.
  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_waddr_d = mem_waddr_q;
    mem_mask_d  = mem_mask_q;
    mem_data_d  = mem_data_q;
    pop         = 1'b0;
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    count_d     = count_q;

    case (state_q)
      S_IDLE: begin
        if (count_q != '0) begin
          mem_waddr_d = addr_mem_q[rd_ptr_q];
          mem_mask_d  = mask_mem_q[rd_ptr_q];
          mem_data_d  = data_mem_q[rd_ptr_q];
          mem_req_d   = 1'b1;
          state_d     = S_REQ;
        end
      end
      S_REQ: begin
        if (mem_ack) begin
          pop       = 1'b1;
          mem_req_d = 1'b0;
          state_d   = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);

    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Conservative same-word hit against valid entries and the store being pushed now.
  always_comb begin
    ld_waddr    = ld_check_addr[ADDR_W-1:2];
    offs        = '0;
    ld_conflict = push && (rob_addr[ADDR_W-1:2] == ld_waddr);
    for (int unsigned i = 0; i < DEPTH; i++) begin
      offs = PTR_W'(i) - rd_ptr_q;
      if ((CNT_W'(offs) < count_q) && (addr_mem_q[i] == ld_waddr)) begin
        ld_conflict = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      mem_req_q   <= 1'b0;
      mem_waddr_q <= '0;
      mem_mask_q  <= '0;
      mem_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      mem_req_q   <= mem_req_d;
      mem_waddr_q <= mem_waddr_d;
      mem_mask_q  <= mem_mask_d;
      mem_data_q  <= mem_data_d;
    end
  end

  // Payload storage needs no reset: validity is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem_q[wr_ptr_q] <= rob_addr[ADDR_W-1:2];
      mask_mem_q[wr_ptr_q] <= rob_mask;
      data_mem_q[wr_ptr_q] <= rob_data;
    end
  end

endmodule

// File: tb/tb_store_commit_buffer.sv
// Bench for store_commit_buffer: queue-based reference model checked every cycle,
// a conflict vector table, and directed sequences for fill, full+pop, wrap and reset.
module tb_store_commit_buffer;

  localparam int unsigned DEPTH = 4;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  mask;
    logic [31:0] data;
  } ent_t;

  typedef struct {
    logic [31:0] check_addr;
    logic        push;
    logic [31:0] push_addr;
    logic        exp_conflict;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rob_write = 1'b0;
  logic [3:0]  rob_mask = '0;
  logic [31:0] rob_addr = '0;
  logic [31:0] rob_data = '0;
  logic        rob_write_valid;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [3:0]  mem_mask;
  logic [31:0] mem_data;
  logic        mem_ack = 1'b0;
  logic [31:0] ld_check_addr = 32'hFFFF_F000;
  logic        ld_conflict;
  logic        buf_empty;

  int n_cmp  = 0;
  int n_fail = 0;
  int dut_writes = 0;

  ent_t mdl_q[$];
  logic mdl_req = 1'b0;

  store_commit_buffer #(.DEPTH(DEPTH), .ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .rob_write(rob_write), .rob_mask(rob_mask), .rob_addr(rob_addr), .rob_data(rob_data),
    .rob_write_valid(rob_write_valid),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_mask(mem_mask), .mem_data(mem_data),
    .mem_ack(mem_ack),
    .ld_check_addr(ld_check_addr), .ld_conflict(ld_conflict), .buf_empty(buf_empty)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push_st(input logic [31:0] a, input logic [3:0] m, input logic [31:0] d);
    rob_write = 1'b1;
    rob_addr  = a;
    rob_mask  = m;
    rob_data  = d;
    cyc();
    rob_write = 1'b0;
  endtask

  // Reference model: checks current outputs, then advances to the state after the next edge.
  always @(negedge clk) begin
    logic push, pop, hit;
    ent_t e;
    chk("rob_write_valid", rob_write_valid, mdl_q.size() < DEPTH);
    chk("buf_empty", buf_empty, (mdl_q.size() == 0) && !mdl_req);
    chk("mem_req", mem_req, mdl_req);
    if (mdl_req && mdl_q.size() != 0) begin
      chk("mem_addr", mem_addr, mdl_q[0].addr & 32'hFFFF_FFFC);
      chk("mem_mask", mem_mask, mdl_q[0].mask);
      chk("mem_data", mem_data, mdl_q[0].data);
    end
    push = !rst && rob_write && (mdl_q.size() < DEPTH);
    hit  = push && (rob_addr[31:2] == ld_check_addr[31:2]);
    foreach (mdl_q[i]) if (mdl_q[i].addr[31:2] == ld_check_addr[31:2]) hit = 1'b1;
    chk("ld_conflict", ld_conflict, hit);

    if (!rst && mem_req && mem_ack) dut_writes++;

    if (rst) begin
      mdl_q.delete();
      mdl_req = 1'b0;
    end else begin
      pop = mdl_req && mem_ack;
      if (pop) begin
        void'(mdl_q.pop_front());
        mdl_req = 1'b0;
      end else if (!mdl_req && mdl_q.size() != 0) begin
        mdl_req = 1'b1;
      end
      if (push) begin
        e.addr = rob_addr;
        e.mask = rob_mask;
        e.data = rob_data;
        mdl_q.push_back(e);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[6];
    int   w0;
    int   target;

    repeat (2) cyc();
    rst = 1'b0;
    chk("reset_rob_write_valid", rob_write_valid, 1);
    chk("reset_buf_empty", buf_empty, 1);
    chk("reset_mem_req", mem_req, 0);
    chk("reset_ld_conflict", ld_conflict, 0);

    // T1 single store and its latency
    w0 = dut_writes;
    push_st(32'h104, 4'b0011, 32'hBEEF);
    chk("t1_req_after_push_edge", mem_req, 0);
    cyc();
    chk("t1_req_second_edge", mem_req, 1);
    chk("t1_mem_addr", mem_addr, 32'h104);
    chk("t1_mem_mask", mem_mask, 4'b0011);
    chk("t1_mem_data", mem_data, 32'hBEEF);
    mem_ack = 1'b1;
    cyc();
    mem_ack = 1'b0;
    chk("t1_buf_empty", buf_empty, 1);
    chk("t1_writes", dut_writes - w0, 1);

    // T2 fill, drop 5th, drain in order
    w0 = dut_writes;
    for (int i = 0; i < 4; i++) push_st(32'h1000 + 32'(i * 4), 4'hF, 32'hA000 + 32'(i));
    chk("t2_full_valid", rob_write_valid, 0);
    push_st(32'h1010, 4'hF, 32'hDEAD);
    chk("t2_still_full", rob_write_valid, 0);
    mem_ack = 1'b1;
    repeat (12) cyc();
    mem_ack = 1'b0;
    chk("t2_writes", dut_writes - w0, 4);
    chk("t2_empty", buf_empty, 1);

    // T3 full + same-cycle pop and push
    w0 = dut_writes;
    for (int i = 0; i < 4; i++) push_st(32'h2000 + 32'(i * 4), 4'h1 << i, 32'hB000 + 32'(i));
    chk("t3_full_req", mem_req, 1);
    rob_write = 1'b1; rob_addr = 32'h2010; rob_mask = 4'hC; rob_data = 32'hB004;
    mem_ack = 1'b1;
    cyc();
    mem_ack = 1'b0;
    chk("t3_slot_opens_after_pop", rob_write_valid, 1);
    cyc();
    rob_write = 1'b0;
    chk("t3_full_again", rob_write_valid, 0);
    mem_ack = 1'b1;
    repeat (14) cyc();
    mem_ack = 1'b0;
    chk("t3_writes", dut_writes - w0, 5);

    // T4 conflict vectors against a buffer holding 0x200
    push_st(32'h200, 4'hF, 32'h1234);
    vecs[0] = '{32'h203, 1'b0, 32'h0,   1'b1};
    vecs[1] = '{32'h204, 1'b0, 32'h0,   1'b0};
    vecs[2] = '{32'h300, 1'b1, 32'h300, 1'b1};
    vecs[3] = '{32'h300, 1'b0, 32'h300, 1'b0};
    vecs[4] = '{32'h1FC, 1'b0, 32'h0,   1'b0};
    vecs[5] = '{32'h200, 1'b0, 32'h0,   1'b1};
    for (int i = 0; i < 6; i++) begin
      ld_check_addr = vecs[i].check_addr;
      rob_write     = vecs[i].push;
      rob_addr      = vecs[i].push_addr;
      #1;
      chk($sformatf("t4_vec%0d", i), ld_conflict, vecs[i].exp_conflict);
      rob_write = 1'b0;
      cyc();
    end
    ld_check_addr = 32'hFFFF_F000;
    mem_ack = 1'b1;
    repeat (4) cyc();
    mem_ack = 1'b0;
    chk("t4_empty", buf_empty, 1);

    // T5 ten stores with random ack delays across pointer wrap
    target = dut_writes + 10;
    fork
      begin : pusher
        for (int i = 0; i < 10; i++) begin
          int g = 0;
          while (!rob_write_valid && g < 60) begin cyc(); g++; end
          if (!rob_write_valid) chk("t5_push_timeout", rob_write_valid, 1);
          ld_check_addr = 32'h400 + 32'($urandom_range(0, 63));
          push_st(32'h400 + 32'($urandom_range(0, 63)), 4'($urandom_range(1, 15)), $urandom);
          repeat ($urandom_range(0, 1)) cyc();
        end
      end
      begin : acker
        while (dut_writes < target) begin
          int g = 0;
          while (!mem_req && g < 60) begin cyc(); g++; end
          if (!mem_req) begin
            chk("t5_req_timeout", mem_req, 1);
            break;
          end
          repeat ($urandom_range(0, 3)) cyc();
          mem_ack = 1'b1;
          cyc();
          mem_ack = 1'b0;
        end
      end
    join
    ld_check_addr = 32'hFFFF_F000;
    repeat (2) cyc();
    chk("t5_writes", dut_writes, target);
    chk("t5_empty", buf_empty, 1);

    // T6 reset while a request is outstanding with three entries
    w0 = dut_writes;
    for (int i = 0; i < 3; i++) push_st(32'h3000 + 32'(i * 4), 4'hF, 32'hC000 + 32'(i));
    chk("t6_req_before_reset", mem_req, 1);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("t6_mem_req", mem_req, 0);
    chk("t6_buf_empty", buf_empty, 1);
    chk("t6_rob_write_valid", rob_write_valid, 1);
    chk("t6_mem_addr", mem_addr, 0);
    mem_ack = 1'b1;
    repeat (6) cyc();
    mem_ack = 1'b0;
    chk("t6_no_writes", dut_writes - w0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
